// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC thermometer capture path.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ENC,
    VALID
  } tdc_cap_state_t;

  localparam int unsigned DROP_W_DEFAULT = 8;

  // Bits needed to hold any count 0..n inclusive.
  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Combinational encoder: number of set bits and highest-set-index+1 of a code.
module tdc_popcount #(
  parameter int unsigned N     = 64,
  parameter int unsigned OUT_W = 7
) (
  input  logic [N-1:0]     code,
  output logic [OUT_W-1:0] ones,
  output logic [OUT_W-1:0] top
);

  always_comb begin
    ones = '0;
    top  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ones = ones + OUT_W'(code[i]);
      if (code[i]) top = OUT_W'(i + 1);
    end
  end

endmodule

// File: rtl/tdc_thermo_capture.sv
// Captures the delay-line thermometer code on a stop strobe, double-flops it,
// encodes it and holds the result on a valid/ready handshake.
module tdc_thermo_capture
  import tdc_pkg::*;
#(
  parameter int unsigned N      = 64,
  parameter int unsigned OUT_W  = clog2p1(N),
  parameter int unsigned DROP_W = DROP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      meas_i,
  input  logic              sample_i,
  output logic [OUT_W-1:0]  result_o,
  output logic [OUT_W-1:0]  edge_o,
  output logic              bubble_o,
  output logic              overflow_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              busy_o
);

  if (N < 2) begin : g_bad_n
    $error("tdc_thermo_capture: N must be at least 2");
  end
  if (OUT_W < clog2p1(N)) begin : g_bad_out_w
    $error("tdc_thermo_capture: OUT_W too narrow to hold 0..N");
  end

  tdc_cap_state_t   state;
  logic [N-1:0]     cap1;
  logic [N-1:0]     cap2;
  logic [OUT_W-1:0] enc_ones;
  logic [OUT_W-1:0] enc_top;

  tdc_popcount #(
    .N     (N),
    .OUT_W (OUT_W)
  ) u_popcount (
    .code (cap2),
    .ones (enc_ones),
    .top  (enc_top)
  );

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap1       <= '0;
      cap2       <= '0;
      result_o   <= '0;
      edge_o     <= '0;
      bubble_o   <= 1'b0;
      overflow_o <= 1'b0;
      valid_o    <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      // Any strobe outside IDLE is lost, including one coincident with the handshake.
      if (sample_i && (state != IDLE) && (drop_cnt_o != '1))
        drop_cnt_o <= drop_cnt_o + DROP_W'(1);

      case (state)
        IDLE: begin
          if (sample_i) begin
            cap1  <= meas_i;
            state <= SYNC;
          end
        end
        SYNC: begin
          cap2  <= cap1;
          state <= ENC;
        end
        ENC: begin
          result_o   <= enc_ones;
          edge_o     <= enc_top;
          bubble_o   <= (enc_ones != enc_top);
          overflow_o <= (cap2 == '1);
          valid_o    <= 1'b1;
          state      <= VALID;
        end
        VALID: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/tdc_thermo_capture.md
Name: tdc_thermo_capture

Overview:
Receiving end of the TDC delay line. Samples the N-bit thermometer code from the delay line on a stop strobe and passes it through a two-flop capture/synchroniser. It encodes the code into a binary tap count, flags bubbles and overflow, and presents the result on a valid/ready handshake to the readout logic. One measurement is in flight at a time.

Parameters:
N, 64, delay-line length; width of meas_i.
OUT_W, $clog2(N+1) (7 for N=64), result width; must represent the values 0..N.
DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
meas_i  input  N  thermometer taps from the delay line; bit 0 is the first tap reached by the pulse.
sample_i  input  1  stop strobe; a 1-cycle pulse requests a capture.
result_o  output  OUT_W  number of set taps, i.e. the popcount of the captured code.
edge_o  output  OUT_W  index of the highest set tap plus 1; 0 when no tap is set.
bubble_o  output  1  result_o != edge_o, meaning the code is not a clean thermometer.
overflow_o  output  1  every tap is set; the pulse outran the line.
valid_o  output  1  result fields are valid.
ready_i  input  1  consumer accepts the result.
drop_cnt_o  output  DROP_W  count of sample_i pulses ignored because the block was busy.
busy_o  output  1  state != IDLE.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - state=IDLE; cap1 and cap2 cleared.
  - result_o=0, edge_o=0, bubble_o=0, overflow_o=0, valid_o=0, drop_cnt_o=0, busy_o=0.
  - Reset overrides every other event. A measurement in progress is discarded and not counted as dropped.
- FSM states: IDLE, SYNC, ENC, VALID.
  - IDLE: on sample_i=1 at edge k, cap1<=meas_i and go to SYNC.
  - SYNC: at edge k+1, cap2<=cap1 and go to ENC. cap1 is never used directly downstream.
  - ENC: at edge k+2, register all result fields from cap2, set valid_o<=1, go to VALID.
    - result_o = popcount(cap2).
    - edge_o = (highest set index)+1.
    - bubble_o = (popcount != edge).
    - overflow_o = (cap2 == all-ones).
  - VALID: hold valid_o and every result field stable while ready_i=0. On ready_i=1 at an edge, valid_o<=0 and go to IDLE. The result fields keep their values after handshake.
- Latency: result is visible the cycle after edge k+2, i.e. 3 cycles from the sample_i cycle. With ready_i tied high, a new sample is accepted no earlier than edge k+4.
- sample_i in any state other than IDLE is ignored, and drop_cnt_o increments; it saturates at 2^DROP_W-1 and never wraps.
- sample_i coincident with ready_i in VALID: the handshake completes, the sample is dropped and counted.
- sample_i held high in IDLE: captures on the first cycle only. Subsequent high cycles during SYNC/ENC/VALID count as drops.
- All-zero code: result_o=0, edge_o=0, bubble_o=0, overflow_o=0.
- All-ones code: result_o=N, edge_o=N, overflow_o=1, bubble_o=0.
- Width rules:
  - Popcount and edge are unsigned OUT_W values with no truncation.
  - N must be at least 2; elaboration fails otherwise.
- meas_i is asynchronous to clk. Only cap1 may go metastable. No combinational path exists from meas_i to any output.

Decomposition:
- Package tdc_pkg holds:
  - the state enum tdc_cap_state_t {IDLE, SYNC, ENC, VALID};
  - the function clog2p1(n) that computes OUT_W;
  - the DROP_W default constant.
- One sub-module, tdc_popcount #(N, OUT_W): purely combinational; outputs the popcount and the highest-set-index+1 of its input. It is instantiated once on cap2, so both values share one ENC cycle.

Test Plan:
- Clean code: meas_i=64'h0000_0000_0000_00FF, pulse sample_i at cycle 0 -> valid_o rises at cycle 3 with result_o=8, edge_o=8, bubble_o=0, overflow_o=0. ready_i=1 at cycle 3 -> valid_o=0 at cycle 4.
- Bubble: meas_i=64'h0000_0000_0000_00FB -> result_o=7, edge_o=8, bubble_o=1.
- Extremes: meas_i=0 -> result_o=0, edge_o=0. meas_i=all-ones -> result_o=64, edge_o=64, overflow_o=1.
- Backpressure:
  - Hold ready_i=0 for 10 cycles after valid_o -> valid_o and all result fields are stable throughout.
  - Pulse sample_i 3 times during that window -> drop_cnt_o=3.
  - A simultaneous sample_i and ready_i -> drop_cnt_o=4 and state IDLE.
- Input changes after capture: change meas_i every cycle after the sample_i edge -> result reflects only the value at the sample edge.
- Reset mid-op: assert rst during ENC -> next cycle valid_o=0, busy_o=0, drop_cnt_o=0. The following sample with meas_i=64'h0F -> result_o=4 after 3 cycles.
- Saturation: 300 dropped samples -> drop_cnt_o=255.
